regfile_access_ctrl: RTL

//   Owns the register-file write port and one read port on behalf of non-pipeline agents.

---
 rtl/regfile_access_ctrl_pkg.sv | 33 +++
 rtl/regfile_access_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl_pkg.sv
// Shared types and helpers for the register-file access controller: index widths,
// vector shapes, controller states and the debug lane-mask helper.
package regfile_access_ctrl_pkg;

    localparam int THREADS_PER_CORE = 4;
    localparam int NUM_REGISTERS    = 32;
    localparam int NUM_VECTOR_LANES = 16;

    localparam int THREAD_IDX_W = $clog2(THREADS_PER_CORE);
    localparam int REG_IDX_W    = $clog2(NUM_REGISTERS);
    localparam int LANE_IDX_W   = $clog2(NUM_VECTOR_LANES);

    typedef logic [THREAD_IDX_W-1:0]           local_thread_idx_t;
    typedef logic [REG_IDX_W-1:0]              register_idx_t;
    typedef logic [NUM_VECTOR_LANES-1:0]       vector_mask_t;
    typedef logic [NUM_VECTOR_LANES-1:0][31:0] vector_t;

    typedef enum logic [2:0] {
        CLEAR_S,
        CLEAR_V,
        IDLE,
        DBG_WR,
        DRAIN,
        RD,
        RD_CAP
    } regfile_ctrl_state_t;

    // Mask bits are numbered from the opposite end to lane indices.
    function automatic vector_mask_t dbg_lane_mask(input logic [LANE_IDX_W-1:0] lane);
        return vector_mask_t'(1) << (LANE_IDX_W'(NUM_VECTOR_LANES - 1) - lane);
    endfunction

endpackage

// File: rtl/regfile_access_ctrl.sv
// Owns the register-file write port and read port 1 for non-pipeline agents: zero-fills
// every register after reset, then arbitrates debug-host accesses against writeback.
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
#(
    parameter int THREADS        = THREADS_PER_CORE,
    parameter int NUM_REGS       = NUM_REGISTERS,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                                clk,
    input  logic                                reset,

    input  logic                                wb_writeback_en,
    input  logic [THREAD_IDX_W-1:0]             wb_writeback_thread_idx,
    input  logic                                wb_writeback_vector,
    input  logic [NUM_VECTOR_LANES-1:0][31:0]   wb_writeback_value,
    input  logic [NUM_VECTOR_LANES-1:0]         wb_writeback_mask,
    input  logic [REG_IDX_W-1:0]                wb_writeback_reg,

    input  logic                                dbg_req,
    input  logic                                dbg_write,
    input  logic [THREAD_IDX_W-1:0]             dbg_thread_idx,
    input  logic                                dbg_vector,
    input  logic [REG_IDX_W-1:0]                dbg_reg,
    input  logic [LANE_IDX_W-1:0]               dbg_lane,
    input  logic [31:0]                         dbg_write_data,
    output logic                                dbg_ack,
    output logic [31:0]                         dbg_read_data,

    output logic                                rf_write_en,
    output logic [THREAD_IDX_W-1:0]             rf_write_thread_idx,
    output logic                                rf_write_vector,
    output logic [NUM_VECTOR_LANES-1:0][31:0]   rf_write_value,
    output logic [NUM_VECTOR_LANES-1:0]         rf_write_mask,
    output logic [REG_IDX_W-1:0]                rf_write_reg,

    output logic                                rf_read_en,
    output logic [THREAD_IDX_W-1:0]             rf_read_thread_idx,
    output logic                                rf_read_vector,
    output logic [REG_IDX_W-1:0]                rf_read_reg,
    input  logic [NUM_VECTOR_LANES-1:0][31:0]   rf_read_data,

    output logic                                rf_issue_block,
    output logic                                rf_init_done
);

    localparam int                  CNT_W       = $clog2(THREADS * NUM_REGS);
    localparam logic [CNT_W-1:0]    LAST_ADDR   = CNT_W'(THREADS * NUM_REGS - 1);
    localparam regfile_ctrl_state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR_S : IDLE;

    regfile_ctrl_state_t state_q, state_d;
    logic [CNT_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic                dbg_ack_q, dbg_ack_d;
    logic [31:0]         dbg_read_data_q, dbg_read_data_d;
    logic                issue_block_q, issue_block_d;
    logic                init_done_q, init_done_d;

    logic [THREAD_IDX_W-1:0] clr_thread;
    logic [REG_IDX_W-1:0]    clr_reg;

    // Clear address is {thread, reg} taken straight from the counter.
    assign clr_thread = THREAD_IDX_W'(clr_cnt_q >> REG_IDX_W);
    assign clr_reg    = clr_cnt_q[REG_IDX_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= RESET_STATE;
            clr_cnt_q       <= '0;
            dbg_ack_q       <= 1'b0;
            dbg_read_data_q <= '0;
            issue_block_q   <= CLEAR_ON_RESET;
            init_done_q     <= !CLEAR_ON_RESET;
        end else begin
            state_q         <= state_d;
            clr_cnt_q       <= clr_cnt_d;
            dbg_ack_q       <= dbg_ack_d;
            dbg_read_data_q <= dbg_read_data_d;
            issue_block_q   <= issue_block_d;
            init_done_q     <= init_done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        clr_cnt_d       = clr_cnt_q;
        dbg_ack_d       = 1'b0;
        dbg_read_data_d = dbg_read_data_q;
        issue_block_d   = issue_block_q;
        init_done_d     = init_done_q;

        rf_write_en         = wb_writeback_en;
        rf_write_thread_idx = wb_writeback_thread_idx;
        rf_write_vector     = wb_writeback_vector;
        rf_write_value      = wb_writeback_value;
        rf_write_mask       = wb_writeback_mask;
        rf_write_reg        = wb_writeback_reg;

        rf_read_en          = 1'b0;
        rf_read_thread_idx  = dbg_thread_idx;
        rf_read_vector      = dbg_vector;
        rf_read_reg         = dbg_reg;

        dbg_ack             = dbg_ack_q;

        unique case (state_q)
            CLEAR_S, CLEAR_V: begin
                // Writeback cannot occur while issue is blocked, so it is simply overridden.
                rf_write_en         = 1'b1;
                rf_write_thread_idx = clr_thread;
                rf_write_vector     = (state_q == CLEAR_V);
                rf_write_value      = '0;
                rf_write_mask       = '1;
                rf_write_reg        = clr_reg;
                if (clr_cnt_q == LAST_ADDR) begin
                    clr_cnt_d = '0;
                    if (state_q == CLEAR_S) begin
                        state_d = CLEAR_V;
                    end else begin
                        state_d       = IDLE;
                        issue_block_d = 1'b0;
                        init_done_d   = 1'b1;
                    end
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end

            IDLE: begin
                // A registered read ack is still visible this cycle while the host
                // has not yet dropped its request; do not restart on it.
                if (dbg_req && !dbg_ack_q) begin
                    if (dbg_write) begin
                        state_d = DBG_WR;
                    end else begin
                        state_d       = DRAIN;
                        issue_block_d = 1'b1;
                    end
                end
            end

            DBG_WR: begin
                if (!wb_writeback_en) begin
                    rf_write_en         = 1'b1;
                    rf_write_thread_idx = dbg_thread_idx;
                    rf_write_vector     = dbg_vector;
                    rf_write_value      = {NUM_VECTOR_LANES{dbg_write_data}};
                    rf_write_mask       = dbg_vector ? dbg_lane_mask(dbg_lane) : '1;
                    rf_write_reg        = dbg_reg;
                    dbg_ack             = 1'b1;
                    state_d             = IDLE;
                end
            end

            DRAIN: begin
                state_d = RD;
            end

            RD: begin
                rf_read_en = 1'b1;
                state_d    = RD_CAP;
            end

            RD_CAP: begin
                dbg_read_data_d = dbg_vector ? rf_read_data[dbg_lane] : rf_read_data[0];
                dbg_ack_d       = 1'b1;
                issue_block_d   = 1'b0;
                state_d         = IDLE;
            end

            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    assign dbg_read_data  = dbg_read_data_q;
    assign rf_issue_block = issue_block_q;
    assign rf_init_done   = init_done_q;

endmodule
